canonical_stream_reducer: RTL and testbench
===========================================

CANONICAL_STREAM_REDUCER -- requirements
Module: canonical_stream_reducer

Interface
REQ-001 Parameter NUM_QUBIT, default 4: stabilizer rows per tableau and qubit columns per row (N).
REQ-002 Parameter MAX_VECTOR, default 2**NUM_QUBIT: phase bits per row (V), one per vector pair.
REQ-003 The module SHALL have one clock and an asynchronous, active-high reset, named clk and rst_new.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rst_new  in  1  asynchronous active-high reset.
REQ-006 in_valid / in_ready  in / out  1 each  input row handshake; beat accepted on an edge where both are 1.
REQ-007 in_literals  in  2N  row literals, qubit q at bits [2q+1:2q]: bit0 = X component, bit1 = Z component (I=00, X=01, Z=10, Y=11).
REQ-008 in_phase  in  V  sign bit per vector (1 = negative).
REQ-009 in_x_only  in  1  mode, sampled with the first accepted beat; 1 skips the Z pass.
REQ-010 out_valid / out_ready  out / in  1 each  output row handshake.
REQ-011 out_literals, out_phase  out  2N, V  reduced row.
REQ-012 out_identity  out  1  out_literals all zero.
REQ-013 out_last  out  1  marks row N-1.
REQ-014 x_rank  out  clog2(N+1)  X-pivot count, held from end of X pass until next first beat.
REQ-015 done  out  1  one-cycle pulse after the last output beat is accepted.

Function
REQ-016 States: IDLE, LOAD, XPASS, ZPASS, DRAIN.
REQ-017 IDLE: in_ready=1; accepted beat is written to row 0; go to LOAD, row counter=1, x_rank cleared.
REQ-018 LOAD: in_ready=1; row r written to row r; in_valid low holds state; after row N-1 is accepted go to XPASS, column=0, pivot_row=0.
REQ-019 XPASS: one column per cycle; pivot = lowest row r >= pivot_row with X bit set at column c.
REQ-020 If a pivot exists: swap it into pivot_row; multiply every other row whose X bit at c is set by the pivot; pivot_row+1; x_rank+1. All in the same cycle.
REQ-021 If no pivot exists: the column is a no-op.
REQ-022 XPASS exit: after column N-1, go to ZPASS (pivot_row carried, column=0), or to DRAIN if x_only.
REQ-023 ZPASS: same per-column rule using the Z bit; candidate and eliminated rows are chosen on the Z bit only. Exit after column N-1 to DRAIN.
REQ-024 Row multiply, target h by pivot i: literals_h ^= literals_i.
REQ-025 Per vector k: s = 2*ph_h[k] + 2*ph_i[k] + sum over q of g(x_i,z_i,x_h,z_h), mod 4.
REQ-026 g = 0 for I; (z_h - x_h) for Y; z_h*(2x_h-1) for X; x_h*(1-2z_h) for Z.
REQ-027 New ph_h[k] = (s==2); the literal update is shared by all V vectors.
REQ-028 DRAIN: out_valid=1, presenting rows 0..N-1 in order; row advances only on out_valid&out_ready; data is held stable while stalled.
REQ-029 After row N-1 is accepted: done=1 for one cycle and return to IDLE. in_ready=0 in XPASS/ZPASS/DRAIN.
REQ-030 Latency: out_valid rises 2N edges (N if x_only) after the edge accepting row N-1; throughput is one row per cycle in LOAD/DRAIN.

Reset
REQ-031 rst_new SHALL at any time, including mid-pass or mid-drain, force IDLE and discard the partial tableau.
REQ-032 Reset values: in_ready=0 while rst_new is high, 1 after release; out_valid=0, done=0, x_rank=0, out_last=0, out_identity=0; row storage all 0.

Verification
REQ-033 N=2,V=2: rows ZZ(0,0), XX(0,1) -> out XX(0,1), ZZ(0,0); x_rank=1; first out_valid 4 edges after last accept.
REQ-034 N=2,V=1: XX(0), XI(0) -> XI(0), IX(0); x_rank=2.
REQ-035 N=2,V=2: XX(0,0), YY(0,1) -> XX(0,0), ZZ(1,0); checks sign rule, since XX*YY = -ZZ.
REQ-036 N=2: in_x_only=1, ZZ, XX -> out XX, ZZ 2 edges after last accept.
REQ-037 Same inputs with out_ready low for 3 cycles mid-DRAIN -> row 1 held unchanged; done pulses once, one edge after the final accept.
REQ-038 rst_new pulsed during ZPASS -> out_valid never asserted; a fresh tableau reduces correctly.

Source files
------------

// File: rtl/canonical_stream_reducer.sv
// Streams in an N-row stabilizer tableau, reduces it to canonical form (X pass, then Z pass), streams it out.
// Output follows the last input row by 2N cycles (N when x_only); the drain holds each row until out_ready.
module canonical_stream_reducer #(
  parameter int NUM_QUBIT  = 4,
  parameter int MAX_VECTOR = 2**NUM_QUBIT
) (
  input  logic                              clk,
  input  logic                              rst_new,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [2*NUM_QUBIT-1:0]            in_literals,
  input  logic [MAX_VECTOR-1:0]             in_phase,
  input  logic                              in_x_only,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [2*NUM_QUBIT-1:0]            out_literals,
  output logic [MAX_VECTOR-1:0]             out_phase,
  output logic                              out_identity,
  output logic                              out_last,
  output logic [$clog2(NUM_QUBIT+1)-1:0]    x_rank,
  output logic                              done
);
  localparam int N  = NUM_QUBIT;
  localparam int V  = MAX_VECTOR;
  localparam int LW = 2 * N;
  localparam int RW = $clog2(N + 1);
  localparam logic [RW-1:0] LAST = RW'(N - 1);

  typedef enum logic [2:0] {IDLE, LOAD, XPASS, ZPASS, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [LW-1:0]       lit_q [N];
  logic [LW-1:0]       lit_d [N];
  logic [V-1:0]        ph_q [N];
  logic [V-1:0]        ph_d [N];
  logic [RW-1:0]       cnt_q, cnt_d, piv_q, piv_d, rank_q, rank_d, piv_idx;
  logic                xo_q, xo_d, done_q, done_d, zsel, found;
  logic [LW-1:0]       piv_lit, top_lit, cur_lit, src_lit;
  logic [V-1:0]        piv_ph, top_ph, cur_ph, src_ph;

  function automatic logic col_bit(input logic [LW-1:0] lit, input logic [RW-1:0] col,
                                   input logic sel_z);
    logic b;
    b = 1'b0;
    for (int q = 0; q < N; q++)
      if (RW'(q) == col) b = sel_z ? lit[2*q+1] : lit[2*q];
    return b;
  endfunction

  // Sign of (row h) * (row i): the i^k exponent sum mod 4 is shared by all vectors.
  function automatic logic [V-1:0] phase_mul(input logic [LW-1:0] lit_h, input logic [V-1:0] ph_h,
                                             input logic [LW-1:0] lit_i, input logic [V-1:0] ph_i);
    logic [1:0]   gsum, g, s;
    logic         xi, zi, xh, zh;
    logic [V-1:0] res;
    gsum = 2'd0;
    for (int q = 0; q < N; q++) begin
      xi = lit_i[2*q];
      zi = lit_i[2*q+1];
      xh = lit_h[2*q];
      zh = lit_h[2*q+1];
      g  = 2'd0;
      if (xi && zi)  g = (zh && !xh) ? 2'd1 : ((xh && !zh) ? 2'd3 : 2'd0);
      else if (xi)   g = zh ? (xh ? 2'd1 : 2'd3) : 2'd0;
      else if (zi)   g = xh ? (zh ? 2'd3 : 2'd1) : 2'd0;
      gsum = gsum + g;
    end
    for (int k = 0; k < V; k++) begin
      s      = {ph_h[k] ^ ph_i[k], 1'b0} + gsum;
      res[k] = (s == 2'd2);
    end
    return res;
  endfunction

  always_comb begin
    zsel    = (state_q == ZPASS);
    found   = 1'b0;
    piv_idx = '0;
    for (int r = N - 1; r >= 0; r--)
      if (RW'(r) >= piv_q && col_bit(lit_q[r], cnt_q, zsel)) begin
        found   = 1'b1;
        piv_idx = RW'(r);
      end
    piv_lit = '0; piv_ph = '0;
    top_lit = '0; top_ph = '0;
    cur_lit = '0; cur_ph = '0;
    for (int r = 0; r < N; r++) begin
      if (RW'(r) == piv_idx) begin piv_lit = lit_q[r]; piv_ph = ph_q[r]; end
      if (RW'(r) == piv_q)   begin top_lit = lit_q[r]; top_ph = ph_q[r]; end
      if (RW'(r) == cnt_q)   begin cur_lit = lit_q[r]; cur_ph = ph_q[r]; end
    end
  end

  always_comb begin
    state_d = state_q;
    lit_d   = lit_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    piv_d   = piv_q;
    rank_d  = rank_q;
    xo_d    = xo_q;
    done_d  = 1'b0;
    src_lit = '0;
    src_ph  = '0;
    case (state_q)
      IDLE: if (in_valid) begin
        lit_d[0] = in_literals;
        ph_d[0]  = in_phase;
        xo_d     = in_x_only;
        rank_d   = '0;
        cnt_d    = RW'(1);
        state_d  = LOAD;
        if (N == 1) begin
          cnt_d   = '0;
          piv_d   = '0;
          state_d = XPASS;
        end
      end
      LOAD: if (in_valid) begin
        for (int r = 0; r < N; r++)
          if (RW'(r) == cnt_q) begin lit_d[r] = in_literals; ph_d[r] = in_phase; end
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          piv_d   = '0;
          state_d = XPASS;
        end else begin
          cnt_d = cnt_q + RW'(1);
        end
      end
      XPASS, ZPASS: begin
        if (found) begin
          // Swap the pivot into piv_q while eliminating the column from every other row.
          for (int r = 0; r < N; r++) begin
            if (RW'(r) == piv_q)        begin src_lit = piv_lit;  src_ph = piv_ph;  end
            else if (RW'(r) == piv_idx) begin src_lit = top_lit;  src_ph = top_ph;  end
            else                        begin src_lit = lit_q[r]; src_ph = ph_q[r]; end
            if (RW'(r) != piv_q && col_bit(src_lit, cnt_q, zsel)) begin
              lit_d[r] = src_lit ^ piv_lit;
              ph_d[r]  = phase_mul(src_lit, src_ph, piv_lit, piv_ph);
            end else begin
              lit_d[r] = src_lit;
              ph_d[r]  = src_ph;
            end
          end
          piv_d = piv_q + RW'(1);
          if (!zsel) rank_d = rank_q + RW'(1);
        end
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = (zsel || xo_q) ? DRAIN : ZPASS;
        end else begin
          cnt_d = cnt_q + RW'(1);
        end
      end
      DRAIN: if (out_ready) begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + RW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_new) begin
    if (rst_new) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst_new) begin
    if (rst_new) begin
      for (int r = 0; r < N; r++) begin
        lit_q[r] <= '0;
        ph_q[r]  <= '0;
      end
      cnt_q  <= '0;
      piv_q  <= '0;
      rank_q <= '0;
      xo_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      lit_q  <= lit_d;
      ph_q   <= ph_d;
      cnt_q  <= cnt_d;
      piv_q  <= piv_d;
      rank_q <= rank_d;
      xo_q   <= xo_d;
      done_q <= done_d;
    end
  end

  assign in_ready     = !rst_new && (state_q == IDLE || state_q == LOAD);
  assign out_valid    = (state_q == DRAIN);
  assign out_literals = cur_lit;
  assign out_phase    = cur_ph;
  assign out_identity = out_valid && (cur_lit == '0);
  assign out_last     = out_valid && (cnt_q == LAST);
  assign x_rank       = rank_q;
  assign done         = done_q;
endmodule

// File: tb/tb_canonical_stream_reducer.sv
// Directed bench for canonical_stream_reducer at N=2, V=2; literal strings list qubit 0 first.
module tb_canonical_stream_reducer;
  localparam int N = 2;
  localparam int V = 2;
  localparam logic [1:0] LI = 2'b00, LX = 2'b01, LZ = 2'b10, LY = 2'b11;
  localparam logic [3:0] XX = {LX, LX}, ZZ = {LZ, LZ}, YY = {LY, LY};
  localparam logic [3:0] XI = {LI, LX}, IX = {LX, LI}, II = {LI, LI};

  logic         clk = 1'b0;
  logic         rst_new = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2*N-1:0] in_literals = '0;
  logic [V-1:0] in_phase = '0;
  logic         in_x_only = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [2*N-1:0] out_literals;
  logic [V-1:0] out_phase;
  logic         out_identity, out_last, done;
  logic [$clog2(N+1)-1:0] x_rank;

  int total = 0;
  int bad   = 0;

  canonical_stream_reducer #(.NUM_QUBIT(N), .MAX_VECTOR(V)) dut (
    .clk(clk), .rst_new(rst_new),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_literals(in_literals), .in_phase(in_phase), .in_x_only(in_x_only),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_literals(out_literals), .out_phase(out_phase),
    .out_identity(out_identity), .out_last(out_last),
    .x_rank(x_rank), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Phase pairs are written (vector0, vector1) -> {vector1, vector0}.
  task automatic load(input logic [3:0] l0, input logic [1:0] p0,
                      input logic [3:0] l1, input logic [1:0] p1, input logic xo);
    in_valid    = 1'b1;
    in_literals = l0;
    in_phase    = p0;
    in_x_only   = xo;
    tick();
    in_literals = l1;
    in_phase    = p1;
    in_x_only   = 1'b0;
    tick();
    in_valid    = 1'b0;
  endtask

  task automatic run_case(input string tag,
                          input logic [3:0] l0, input logic [1:0] p0,
                          input logic [3:0] l1, input logic [1:0] p1, input logic xo,
                          input logic [3:0] e0, input logic [1:0] q0,
                          input logic [3:0] e1, input logic [1:0] q1,
                          input int lat, input int rank, input int stall);
    int n;
    load(l0, p0, l1, p1, xo);
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 40);
    chk({tag, ":latency"}, n, lat);
    chk({tag, ":x_rank"}, 32'(x_rank), rank);
    chk({tag, ":in_ready_drain"}, 32'(in_ready), 0);
    chk({tag, ":row0_lit"}, 32'(out_literals), 32'(e0));
    chk({tag, ":row0_ph"}, 32'(out_phase), 32'(q0));
    chk({tag, ":row0_last"}, 32'(out_last), 0);
    chk({tag, ":row0_id"}, 32'(out_identity), 32'(e0 == 4'd0));
    tick();
    if (stall > 0) begin
      out_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
        chk({tag, ":stall_lit"}, 32'(out_literals), 32'(e1));
        chk({tag, ":stall_ph"}, 32'(out_phase), 32'(q1));
        chk({tag, ":stall_valid"}, 32'(out_valid), 1);
        chk({tag, ":stall_done"}, 32'(done), 0);
        tick();
      end
      out_ready = 1'b1;
    end
    chk({tag, ":row1_lit"}, 32'(out_literals), 32'(e1));
    chk({tag, ":row1_ph"}, 32'(out_phase), 32'(q1));
    chk({tag, ":row1_last"}, 32'(out_last), 1);
    chk({tag, ":row1_id"}, 32'(out_identity), 32'(e1 == 4'd0));
    tick();
    chk({tag, ":done"}, 32'(done), 1);
    chk({tag, ":valid_after"}, 32'(out_valid), 0);
    tick();
    chk({tag, ":done_once"}, 32'(done), 0);
  endtask

  initial begin
    int seen;
    repeat (3) tick();
    chk("rst:in_ready", 32'(in_ready), 0);
    chk("rst:out_valid", 32'(out_valid), 0);
    chk("rst:done", 32'(done), 0);
    chk("rst:x_rank", 32'(x_rank), 0);
    chk("rst:out_last", 32'(out_last), 0);
    chk("rst:out_identity", 32'(out_identity), 0);
    chk("rst:out_literals", 32'(out_literals), 0);
    rst_new = 1'b0;
    tick();
    chk("rst:in_ready_release", 32'(in_ready), 1);

    run_case("zz_xx",   ZZ, 2'b00, XX, 2'b10, 1'b0, XX, 2'b10, ZZ, 2'b00, 4, 1, 0);
    run_case("xx_xi",   XX, 2'b00, XI, 2'b00, 1'b0, XI, 2'b00, IX, 2'b00, 4, 2, 0);
    run_case("sign",    XX, 2'b00, YY, 2'b10, 1'b0, XX, 2'b00, ZZ, 2'b01, 4, 1, 0);
    run_case("xonly",   ZZ, 2'b00, XX, 2'b00, 1'b1, XX, 2'b00, ZZ, 2'b00, 2, 1, 0);
    run_case("stall",   ZZ, 2'b00, XX, 2'b00, 1'b1, XX, 2'b00, ZZ, 2'b00, 2, 1, 3);

    // Abort a reduction once it has entered the Z pass.
    load(ZZ, 2'b00, XX, 2'b10, 1'b0);
    tick();
    tick();
    rst_new = 1'b1;
    seen = 0;
    chk("abort:in_ready_rst", 32'(in_ready), 0);
    tick();
    if (out_valid) seen++;
    rst_new = 1'b0;
    chk("abort:x_rank", 32'(x_rank), 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("abort:no_valid", seen, 0);
    chk("abort:in_ready", 32'(in_ready), 1);
    run_case("fresh",   XI, 2'b00, II, 2'b10, 1'b0, XI, 2'b00, II, 2'b10, 4, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
